// File: rtl/l2_mem_adapter.sv
// L2-to-memory adapter: captures one bus request, drives a single downstream access
// with busy-stall timeout, and reports completion or error for one cycle.
module l2_mem_adapter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        l2REN,
    input  logic        l2WEN,
    input  logic [31:0] l2addr,
    input  logic [31:0] l2store,
    input  logic [3:0]  l2_byte_en,
    output logic [31:0] l2load,
    output logic [1:0]  l2state,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    input  logic        mem_error
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    // State encodings equal the l2state codes so the status output is a plain register.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2,
        StErr  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [31:0]     r_addr;
    logic [31:0]     r_store;
    logic [3:0]      r_be;
    logic            r_is_write;
    logic [31:0]     r_load;
    logic            w_accept;
    logic            w_load_en;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_accept  = 1'b0;
        w_load_en = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (l2REN || l2WEN) begin
                    w_accept = 1'b1;
                    w_cnt_d  = '0;
                    if ((l2REN && l2WEN) || (l2addr[1:0] != 2'b00)) begin
                        w_state_d = StErr;
                    end else begin
                        w_state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (!mem_busy) begin
                    w_state_d = mem_error ? StErr : StResp;
                    w_load_en = !mem_error && !r_is_write;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                    if (r_cnt == CntLast) begin
                        w_state_d = StErr;
                    end
                end
            end
            StResp:  w_state_d = StIdle;
            StErr:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_store    <= '0;
            r_be       <= '0;
            r_is_write <= 1'b0;
            r_load     <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_addr     <= l2addr;
                r_store    <= l2store;
                r_be       <= l2_byte_en;
                r_is_write <= l2WEN;
            end
            if (w_load_en) begin
                r_load <= mem_rdata;
            end
        end
    end

    // Strobes decode only the state register, so reset drops them asynchronously.
    assign l2state     = r_state;
    assign l2load      = r_load;
    assign mem_ren     = (r_state == StReq) && !r_is_write;
    assign mem_wen     = (r_state == StReq) && r_is_write;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_store;
    assign mem_byte_en = r_be;

endmodule

// File: tb/tb_l2_mem_adapter.sv
// Scoreboard bench for l2_mem_adapter: stimulus pushes model responses, a negedge
// monitor pops and compares whenever L2_ACCESS or L2_ERROR is presented.
module tb_l2_mem_adapter;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [1:0] L2_FREE   = 2'd0;
    localparam logic [1:0] L2_BUSY   = 2'd1;
    localparam logic [1:0] L2_ACCESS = 2'd2;
    localparam logic [1:0] L2_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        l2REN = 1'b0;
    logic        l2WEN = 1'b0;
    logic [31:0] l2addr = '0;
    logic [31:0] l2store = '0;
    logic [3:0]  l2_byte_en = '0;
    logic [31:0] l2load;
    logic [1:0]  l2state;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata = '0;
    logic        mem_busy = 1'b0;
    logic        mem_error = 1'b0;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] load;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] model_load = '0;
    int          n_vec = 0;
    int          n_err = 0;

    l2_mem_adapter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .l2REN       (l2REN),
        .l2WEN       (l2WEN),
        .l2addr      (l2addr),
        .l2store     (l2store),
        .l2_byte_en  (l2_byte_en),
        .l2load      (l2load),
        .l2state     (l2state),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byte_en (mem_byte_en),
        .mem_rdata   (mem_rdata),
        .mem_busy    (mem_busy),
        .mem_error   (mem_error)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Outcome of one transaction from the behavioural rules alone.
    function automatic resp_t model(input bit rd, input bit wr, input logic [31:0] addr,
                                    input int nbusy, input bit err, input logic [31:0] rdata);
        resp_t r;
        if ((rd && wr) || addr[1:0] != 2'b00 || nbusy >= int'(TIMEOUT) || err) begin
            r.st = L2_ERROR;
        end else begin
            r.st = L2_ACCESS;
            if (rd) model_load = rdata;
        end
        r.load = model_load;
        return r;
    endfunction

    always @(negedge CLK) begin
        if (nRST && (l2state == L2_ACCESS || l2state == L2_ERROR)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_resp: got state %0d, required no response", l2state);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("resp_state", 128'(l2state), 128'(e.st));
                check("resp_load", 128'(l2load), 128'(e.load));
            end
        end
    end

    // Called at #1 after a posedge with the DUT idle; returns at #1 after the IDLE edge.
    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input int nbusy,
                          input bit err, input logic [31:0] rdata, input bit hold,
                          input string tag);
        int nreq;
        bit proto;
        l2REN      = rd;
        l2WEN      = wr;
        l2addr     = addr;
        l2store    = data;
        l2_byte_en = be;
        mem_busy   = 1'b1;
        mem_error  = 1'b0;
        proto      = (rd && wr) || (addr[1:0] != 2'b00);
        exp_q.push_back(model(rd, wr, addr, nbusy, err, rdata));
        @(posedge CLK);
        #1;
        if (proto) begin
            check({tag, "_nostrobe"}, 128'({mem_ren, mem_wen}), 128'(0));
        end else begin
            nreq = (nbusy + 1 < int'(TIMEOUT)) ? nbusy + 1 : int'(TIMEOUT);
            for (int i = 0; i < nreq; i++) begin
                check({tag, "_req"},
                      128'({l2state, mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en}),
                      128'({L2_BUSY, rd, wr, addr, data, be}));
                mem_busy   = (i < nbusy);
                mem_error  = (i == nbusy) ? err : 1'($urandom);
                mem_rdata  = (i == nbusy) ? rdata : $urandom;
                l2REN      = 1'($urandom);
                l2WEN      = 1'($urandom);
                l2addr     = $urandom;
                l2store    = $urandom;
                l2_byte_en = 4'($urandom);
                @(posedge CLK);
                #1;
            end
        end
        check({tag, "_strobe_off"}, 128'({mem_ren, mem_wen}), 128'(0));
        l2REN    = hold;
        l2WEN    = 1'b0;
        mem_busy = 1'($urandom);
        @(posedge CLK);
        #1;
        check({tag, "_free"}, 128'(l2state), 128'(L2_FREE));
    endtask

    initial begin
        #2 nRST = 1'b0;
        #2;
        check("reset_outputs",
              128'({l2state, l2load, mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en}),
              128'(0));
        @(posedge CLK);
        #1 nRST = 1'b1;
        @(posedge CLK);
        #1;

        do_txn(1, 0, 32'h100, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF, 0, "rd_zero_wait");
        do_txn(0, 1, 32'h204, 32'h12345678, 4'b0011, 3, 0, 32'h0, 0, "wr_busy3");
        do_txn(1, 0, 32'h40, 32'h0, 4'hF, 10, 0, 32'h0, 0, "timeout");
        do_txn(1, 1, 32'h80, 32'h0, 4'hF, 0, 0, 32'h0, 0, "both_req");
        do_txn(1, 0, 32'h102, 32'h0, 4'hF, 0, 0, 32'h0, 0, "misaligned");
        do_txn(1, 0, 32'h110, 32'h0, 4'hF, 1, 1, 32'hBAD0BAD0, 0, "mem_error");
        do_txn(1, 0, 32'h120, 32'h0, 4'hF, 0, 0, 32'hA5A5A5A5, 1, "b2b_first");
        do_txn(1, 0, 32'h124, 32'h0, 4'hF, 2, 0, 32'h5A5A5A5A, 0, "b2b_second");

        for (int k = 0; k < 40; k++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_txn(sel <= 4 || sel == 9, sel >= 5, a, $urandom, 4'($urandom),
                   $urandom_range(0, 5), $urandom_range(0, 7) == 0, $urandom,
                   1'($urandom), "rand");
        end
        l2REN = 1'b0;
        l2WEN = 1'b0;

        // Reset during a stalled read: strobe must drop without waiting for a clock.
        l2REN    = 1'b1;
        l2addr   = 32'h300;
        mem_busy = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_req_strobe", 128'({l2state, mem_ren}), 128'({L2_BUSY, 1'b1}));
        l2REN = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b0;
        #1;
        check("rst_async",
              128'({mem_ren, mem_wen, l2state, l2load, mem_addr}), 128'(0));
        model_load = '0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        mem_busy = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_after", 128'({l2state, l2load, mem_ren}), 128'(0));

        do_txn(1, 0, 32'h400, 32'h0, 4'hF, 0, 0, 32'hC0FFEE00, 0, "post_reset");
        repeat (3) @(posedge CLK);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_resp: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l2_mem_adapter.md
L2_MEM_ADAPTER -- requirements
Module: l2_mem_adapter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of consecutive busy cycles tolerated per memory access (legal range 2..1024).
REQ-002 The block SHALL have the following ports:
- CLK  in  1  sole clock, rising-edge.
- nRST  in  1  asynchronous active-low reset.
- l2REN  in  1  read request from bus controller.
- l2WEN  in  1  write request from bus controller.
- l2addr  in  32  byte address.
- l2store  in  32  write data.
- l2_byte_en  in  4  byte lane enables.
- l2load  out  32  read data returned to bus controller.
- l2state  out  2  l2_state_t status: L2_FREE, L2_BUSY, L2_ACCESS, L2_ERROR.
- mem_ren  out  1  downstream read strobe.
- mem_wen  out  1  downstream write strobe.
- mem_addr  out  32  downstream address.
- mem_wdata  out  32  downstream write data.
- mem_byte_en  out  4  downstream byte enables.
- mem_rdata  in  32  downstream read data, valid when mem_busy is low.
- mem_busy  in  1  downstream stall; access completes in the first strobe cycle with mem_busy low.
- mem_error  in  1  downstream error, sampled only in the completing cycle.
REQ-003 Clocking SHALL be one clock (CLK), and reset (nRST) SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, REQ, RESP, ERR, with l2state = L2_FREE, L2_BUSY, L2_ACCESS, L2_ERROR respectively, registered (no combinational path from inputs to l2state).
REQ-005 IDLE SHALL accept a request in any cycle where l2REN or l2WEN is high, registering l2addr, l2store, l2_byte_en and the operation type.
REQ-006 On accept, the next state SHALL be REQ, except:
- both l2REN and l2WEN high -> ERR;
- l2addr[1:0] != 0 -> ERR.
No memory strobe SHALL be issued in either error case.
REQ-007 In REQ, the block SHALL drive mem_ren or mem_wen (per the captured type) together with mem_addr, mem_wdata and mem_byte_en from the capture registers; all mem outputs SHALL be stable for the whole REQ stay.
REQ-008 Outside REQ, mem_ren and mem_wen SHALL be 0.
REQ-009 The block SHALL ignore changes on the l2 inputs while in REQ, RESP or ERR.
REQ-010 REQ completion: in the first REQ cycle with mem_busy = 0:
- mem_error = 0 -> RESP; for a read, mem_rdata is also captured into l2load;
- mem_error = 1 -> ERR; l2load is unchanged.
REQ-011 Busy counter: width $clog2(TIMEOUT+1); cleared on entry to REQ; incremented in each REQ cycle with mem_busy = 1.
REQ-012 Timeout: in a REQ cycle with mem_busy = 1 and counter = TIMEOUT-1, the next state SHALL be ERR (i.e. after TIMEOUT consecutive busy cycles).
REQ-013 Minimum latency from an accept cycle (cycle 0) SHALL be: REQ in cycle 1; with mem_busy low in cycle 1, L2_ACCESS in cycle 2.
REQ-014 RESP and ERR SHALL each last exactly one cycle and then return to IDLE.
REQ-015 A request present in the IDLE cycle after RESP or ERR SHALL be accepted as a new request; the bus controller deasserts l2REN/l2WEN on seeing L2_ACCESS or L2_ERROR.
REQ-016 l2load SHALL hold its last captured read value indefinitely; writes and errors SHALL NOT modify it.

Reset
REQ-017 While nRST = 0 the block SHALL asynchronously force: state IDLE, l2state = L2_FREE, l2load = 0, mem_ren = mem_wen = 0, mem_addr = mem_wdata = 0, mem_byte_en = 0, counter = 0, capture registers = 0.
REQ-018 Reset asserted mid-access (in REQ) SHALL drop the mem strobes immediately and discard the pending request; after reset release the block is in IDLE and no L2_ACCESS is produced for the discarded request.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Read, zero wait: l2REN=1, l2addr=0x100, mem_busy=0, mem_rdata=0xDEADBEEF -> cycle 1 mem_ren=1 with mem_addr=0x100; cycle 2 l2state=L2_ACCESS, l2load=0xDEADBEEF; cycle 3 L2_FREE.
- Write, 3 busy cycles: l2WEN=1, l2addr=0x204, l2store=0x12345678, l2_byte_en=4'b0011 -> mem_wen=1 with stable mem_addr/mem_wdata/mem_byte_en for 4 cycles; L2_ACCESS one cycle after mem_busy falls; l2load unchanged.
- Timeout, TIMEOUT=4: mem_busy held 1 -> exactly 4 REQ cycles, then L2_ERROR for one cycle, then L2_FREE with mem_ren=0.
- Protocol errors:
  - l2REN=l2WEN=1 -> L2_ERROR in the cycle after accept, no mem strobe;
  - l2addr=0x102 -> same response.
- mem_error=1 on the completing cycle of a read -> L2_ERROR, l2load keeps its prior value.
- Back-to-back: a read held across the L2_ACCESS cycle -> a second access starts (REQ) in the cycle after the following IDLE.
- Reset in REQ: nRST pulsed low during a busy read -> mem_ren=0 asynchronously; after release l2state=L2_FREE, l2load=0.
